// File: rtl/ula_arbiter.sv
// rtl/ula_arbiter.sv - two-requester round-robin arbiter sharing one ULA, with ack timeout
module ula_arbiter #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req0,
  input  logic             i_req1,
  input  logic [WIDTH-1:0] i_op1_0,
  input  logic [WIDTH-1:0] i_op2_0,
  input  logic [WIDTH-1:0] i_op1_1,
  input  logic [WIDTH-1:0] i_op2_1,
  input  logic [3:0]       i_sel_0,
  input  logic [3:0]       i_sel_1,
  output logic             o_gnt0,
  output logic             o_gnt1,
  output logic             o_done0,
  output logic             o_done1,
  output logic [WIDTH-1:0] o_res_out,
  output logic             o_err,
  output logic             o_ula_ena,
  output logic [WIDTH-1:0] o_ula_op1,
  output logic [WIDTH-1:0] o_ula_op2,
  output logic [3:0]       o_ula_op_sel,
  input  logic [WIDTH-1:0] i_ula_res,
  input  logic             i_ula_ack
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [3:0] LP_LAST = 4'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_next;
  logic             r_ptr;
  logic             r_owner;
  logic [3:0]       r_cnt;
  logic [WIDTH-1:0] r_op1;
  logic [WIDTH-1:0] r_op2;
  logic [3:0]       r_sel;
  logic [WIDTH-1:0] r_res;
  logic             r_err;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_busy;
  logic             w_resp;

  always_comb begin
    w_next = r_state;
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // With both requesting, the pointer names the requester that goes first.
        if (i_req0 && (!i_req1 || !r_ptr)) begin
          w_gnt0 = 1'b1;
        end else if (i_req1) begin
          w_gnt1 = 1'b1;
        end
        if (w_gnt0 || w_gnt1) begin
          w_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (i_ula_ack || (r_cnt == LP_LAST)) begin
          w_next = ST_RESP;
        end
      end
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= 1'b0;
      r_owner <= 1'b0;
      r_cnt   <= '0;
      r_op1   <= '0;
      r_op2   <= '0;
      r_sel   <= '0;
      r_res   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_gnt0) begin
            r_owner <= 1'b0;
            r_op1   <= i_op1_0;
            r_op2   <= i_op2_0;
            r_sel   <= i_sel_0;
          end else if (w_gnt1) begin
            r_owner <= 1'b1;
            r_op1   <= i_op1_1;
            r_op2   <= i_op2_1;
            r_sel   <= i_sel_1;
          end
        end
        ST_BUSY: begin
          // Ack is checked first so it wins over a coincident timeout.
          if (i_ula_ack) begin
            r_res <= i_ula_res;
            r_err <= 1'b0;
          end else if (r_cnt == LP_LAST) begin
            r_res <= '0;
            r_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        ST_RESP: r_ptr <= ~r_owner;
        default: ;
      endcase
    end
  end

  // Reset forces every output low, even if the state register is still mid-operation.
  assign w_busy = (r_state == ST_BUSY) && !i_rst;
  assign w_resp = (r_state == ST_RESP) && !i_rst;

  assign o_gnt0       = w_gnt0 && !i_rst;
  assign o_gnt1       = w_gnt1 && !i_rst;
  assign o_done0      = w_resp && !r_owner;
  assign o_done1      = w_resp && r_owner;
  assign o_res_out    = w_resp ? r_res : '0;
  assign o_err        = w_resp && r_err;
  assign o_ula_ena    = w_busy;
  assign o_ula_op1    = w_busy ? r_op1 : '0;
  assign o_ula_op2    = w_busy ? r_op2 : '0;
  assign o_ula_op_sel = w_busy ? r_sel : '0;

endmodule
